// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adder_pkg
// Description : Shared constants, FSM state encoding and sizing helper for the
//               nibble-serial add/subtract sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package adder_pkg;

    // Width of the shared carry-lookahead slice.
    localparam int SLICE_W = 4;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Number of slice cycles needed to cover one operand.
    function automatic int calc_nslice(input int width);
        return width / SLICE_W;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adder_seq_ctrl_cla4_slice.sv
`default_nettype none
// ============================================================================
// Module      : cla4_slice
// Description : 4-bit carry-lookahead adder slice. Purely combinational; all
//               internal carries come from generate/propagate terms rather
//               than rippling bit to bit.
// Revision    : 1.0 - initial release
// ============================================================================
module cla4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_c;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Flattened lookahead equations for every carry in the nibble.
    assign w_c[0] = cin;
    assign w_c[1] = w_g[0] | (w_p[0] & cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & cin);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);

    genvar i;
    generate
        for (i = 0; i < 4; i++) begin : g_sum
            assign sum[i] = w_p[i] ^ w_c[i];
        end
    endgenerate

    assign cout = w_c[4];

endmodule
`default_nettype wire

// File: rtl/adder_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : adder_seq_ctrl
// Description : Multi-precision add/subtract sequencer. Processes one nibble
//               per cycle through a single CLA slice, LS nibble first, with
//               the slice carry-out registered between nibbles. Operands and
//               results use valid/ready handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_seq_ctrl
    import adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   s,
    output logic             busy
);

    localparam int NSLICE = calc_nslice(WIDTH);
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NSLICE - 1);

    state_t             r_state;
    logic [IDX_W-1:0]   r_idx;
    logic               r_carry;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH:0]     r_s;
    logic               r_out_valid;

    logic [SLICE_W-1:0] w_a_nib;
    logic [SLICE_W-1:0] w_b_nib;
    logic [SLICE_W-1:0] w_sum;
    logic               w_cout;

    // Current nibble of the latched operands feeds the shared slice.
    assign w_a_nib = r_a[r_idx*SLICE_W +: SLICE_W];
    assign w_b_nib = r_b[r_idx*SLICE_W +: SLICE_W];

    cla4_slice u_slice (
        .a    (w_a_nib),
        .b    (w_b_nib),
        .cin  (r_carry),
        .sum  (w_sum),
        .cout (w_cout)
    );

    // Sequencer: accept, step one nibble per edge, then hold the result until taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_s         <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        // Subtraction is a + ~b + 1: invert B here, carry-in of 1.
                        r_a     <= a;
                        r_b     <= b ^ {WIDTH{op_sub}};
                        r_carry <= op_sub;
                        r_idx   <= '0;
                        r_s     <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_s[r_idx*SLICE_W +: SLICE_W] <= w_sum;
                    r_carry <= w_cout;
                    if (r_idx == C_LAST_IDX) begin
                        r_s[WIDTH]  <= w_cout;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign out_valid = r_out_valid;
    assign s         = r_s;

endmodule
`default_nettype wire

// File: tb/tb_adder_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_seq_ctrl
// Description : Self-checking bench for adder_seq_ctrl (WIDTH=16): directed
//               cases, back-pressure, busy-ignore, mid-run reset and random
//               operations against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_seq_ctrl;

    localparam int WIDTH   = 16;
    localparam int LATENCY = WIDTH / 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic             op_sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   s;
    logic             busy;

    int checks = 0;
    int errors = 0;

    adder_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_sub    (op_sub),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: add gives the full (WIDTH+1)-bit sum; sub gives the
    // wrapped difference with the top bit meaning "a >= b".
    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y,
                                              input logic sub);
        logic [WIDTH-1:0] diff;
        if (!sub) return {1'b0, x} + {1'b0, y};
        diff = x - y;
        return {(x >= y), diff};
    endfunction

    // One full operation: accept, measure latency, hold back-pressure, release.
    task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                          input logic tsub, input int hold, input bit inject);
        logic [WIDTH:0] exp;
        int lat;
        exp = model(ta, tb, tsub);
        @(negedge clk);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1; a = ta; b = tb; op_sub = tsub;
        @(posedge clk); #1;
        in_valid = 1'b0;
        // Scramble operands after acceptance; the latched copies must be used.
        a = WIDTH'($urandom); b = WIDTH'($urandom); op_sub = ~tsub;
        lat = 0;
        while (!out_valid && lat < 20) begin
            if (inject) begin
                in_valid = 1'b1;
                a = WIDTH'($urandom); b = WIDTH'($urandom);
                check("in_ready_run", 32'(in_ready), 32'd0);
            end
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        check("latency", 32'(lat), 32'(LATENCY));
        check("result", 32'(s), 32'(exp));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_s", 32'(s), 32'(exp));
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        check("done_busy", 32'(busy), 32'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("rel_valid", 32'(out_valid), 32'd0);
        check("rel_in_ready", 32'(in_ready), 32'd1);
        check("rel_s_hold", 32'(s), 32'(exp));
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; op_sub = 1'b0; a = '0; b = '0; out_ready = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_s", 32'(s), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;

        // Directed cases.
        run_op(16'h1234, 16'h4321, 1'b0, 0, 1'b0);
        check("add_basic", 32'(s), 32'h05555);
        run_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
        check("add_ripple", 32'(s), 32'h10000);
        run_op(16'h0005, 16'h0007, 1'b1, 0, 1'b0);
        check("sub_borrow", 32'(s), 32'h0FFFE);
        run_op(16'h0007, 16'h0005, 1'b1, 0, 1'b0);
        check("sub_noborrow", 32'(s), 32'h10002);
        run_op(16'hABCD, 16'hABCD, 1'b1, 0, 1'b0);
        check("sub_equal", 32'(s), 32'h10000);

        // Back-pressure for 10 cycles.
        run_op(16'h8000, 16'h8000, 1'b0, 10, 1'b0);
        // New requests during RUN must be ignored.
        run_op(16'h0F0F, 16'h00F1, 1'b0, 0, 1'b1);
        check("busy_ignore", 32'(s), 32'h01000);

        // Reset in the middle of RUN (slice 2).
        @(negedge clk);
        in_valid = 1'b1; a = 16'h1111; b = 16'h2222; op_sub = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_s", 32'(s), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check("no_late_result", 32'(out_valid), 32'd0);
        end
        run_op(16'h1111, 16'h2222, 1'b0, 0, 1'b0);
        check("after_rst", 32'(s), 32'h03333);

        // Random operations against the model.
        for (int n = 0; n < 30; n++) begin
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
